// File: rtl/resource_sharing_control.sv
`timescale 1ns / 1ps
// resource_sharing_control: time-shares one ISERDES/IODELAY alignment
// engine across NUM_CHANNELS ADC channels. On training_start it walks
// chan_sel through 0..NUM_CHANNELS-1, lets the channel mux settle for
// SETTLE_CYCLES clocks, pulses start_align and waits for data_aligned.
// After the last channel aligns, all_channels_aligned is raised.
//
// Ports:
//   clk                   system clock, rising edge
//   rst                   synchronous active-high reset
//   training_start        1-cycle request to (re)start the sweep
//   data_aligned          1-cycle pulse: current channel aligned
//   chan_sel[3:0]         channel currently routed to the engine
//   start_align           1-cycle pulse: engine starts on chan_sel
//   all_channels_aligned  level, high once every channel aligned
//
// Optional: define ALIGN_TIMEOUT_EN to add a per-attempt watchdog of
// TIMEOUT_CYCLES clocks in WAIT; on expiry the same channel is retried.

module resource_sharing_control #(
    parameter int NUM_CHANNELS   = 10,
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       training_start,
    input  logic       data_aligned,
    output logic [3:0] chan_sel,
    output logic       start_align,
    output logic       all_channels_aligned
);

    if (NUM_CHANNELS < 1 || NUM_CHANNELS > 16 ||
        SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255 ||
        TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("resource_sharing_control: illegal parameter value");
    end

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        PULSE,
        WAIT,
        DONE
    } state_t;

    localparam logic [3:0] LAST_CH     = 4'(NUM_CHANNELS - 1);
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    state_t     state, state_nxt;
    logic [7:0] settle_cnt, settle_nxt;
    logic [3:0] chan_nxt;
    logic       pulse_nxt;
    logic       done_nxt;

`ifdef ALIGN_TIMEOUT_EN
    // Watchdog spans TIMEOUT_CYCLES+1 WAIT cycles so that a data_aligned
    // arriving on the expiry cycle itself is still taken as success.
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES);

    logic [WD_W-1:0] wd_cnt, wd_nxt;
`endif

    always_comb begin
        state_nxt  = state;
        settle_nxt = settle_cnt;
        chan_nxt   = chan_sel;
        pulse_nxt  = 1'b0;
        done_nxt   = all_channels_aligned;
`ifdef ALIGN_TIMEOUT_EN
        wd_nxt     = wd_cnt;
`endif
        if (training_start) begin
            // restart wins over everything, including data_aligned
            state_nxt  = SETTLE;
            settle_nxt = '0;
            chan_nxt   = '0;
            done_nxt   = 1'b0;
        end else begin
            unique case (state)
                IDLE: ;
                SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state_nxt  = PULSE;
                        settle_nxt = '0;
                        pulse_nxt  = 1'b1;
                    end else begin
                        settle_nxt = settle_cnt + 8'd1;
                    end
                end
                PULSE: begin
                    state_nxt = WAIT;
`ifdef ALIGN_TIMEOUT_EN
                    wd_nxt    = '0;
`endif
                end
                WAIT: begin
                    if (data_aligned) begin
                        if (chan_sel == LAST_CH) begin
                            state_nxt = DONE;
                            chan_nxt  = '0;
                            done_nxt  = 1'b1;
                        end else begin
                            state_nxt  = SETTLE;
                            settle_nxt = '0;
                            chan_nxt   = chan_sel + 4'd1;
                        end
                    end
`ifdef ALIGN_TIMEOUT_EN
                    else if (wd_cnt == WD_LAST) begin
                        state_nxt  = SETTLE;
                        settle_nxt = '0;
                    end else begin
                        wd_nxt = wd_cnt + 1'b1;
                    end
`endif
                end
                DONE: ;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                <= IDLE;
            settle_cnt           <= '0;
            chan_sel             <= '0;
            start_align          <= 1'b0;
            all_channels_aligned <= 1'b0;
`ifdef ALIGN_TIMEOUT_EN
            wd_cnt               <= '0;
`endif
        end else begin
            state                <= state_nxt;
            settle_cnt           <= settle_nxt;
            chan_sel             <= chan_nxt;
            start_align          <= pulse_nxt;
            all_channels_aligned <= done_nxt;
`ifdef ALIGN_TIMEOUT_EN
            wd_cnt               <= wd_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_resource_sharing_control.sv
`timescale 1ns / 1ps
// Bench for resource_sharing_control: directed scenarios plus random
// stimulus, checked each cycle against an event-time reference model.

module tb_resource_sharing_control;

    localparam int NC = 10;
    localparam int SC = 4;
`ifdef ALIGN_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 4096;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       training_start = 1'b0;
    logic       data_aligned = 1'b0;
    logic [3:0] chan_sel;
    logic       start_align;
    logic       all_channels_aligned;

    always #2.5 clk = ~clk;

    resource_sharing_control #(
        .NUM_CHANNELS  (NC),
        .SETTLE_CYCLES (SC),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .training_start      (training_start),
        .data_aligned        (data_aligned),
        .chan_sel            (chan_sel),
        .start_align         (start_align),
        .all_channels_aligned(all_channels_aligned)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: timeline of expected events.
    //   cyc       index of the cycle following the latest edge
    //   pulse_at  cycle in which start_align is due (-1 none)
    //   m_wait    engine owns the channel, data_aligned is honoured
    int cyc = 0;
    int pulse_at = -1;
    int wait_start = 0;
    int m_ch = 0;
    bit m_done = 1'b0;
    bit m_wait = 1'b0;
    int m_pulses = 0;
    int dut_pulses = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     tag, obs, exp, cyc);
        end
    endtask

    task automatic model(input bit r, input bit t, input bit d);
        int  c;
        bit  was_pulse;
        c = cyc;
        was_pulse = (c == pulse_at);
        if (r) begin
            m_ch = 0; m_done = 0; m_wait = 0; pulse_at = -1;
        end else if (t) begin
            m_ch = 0; m_done = 0; m_wait = 0; pulse_at = c + SC + 1;
        end else begin
            if (m_wait && d) begin
                m_wait = 0;
                if (m_ch == NC - 1) begin
                    m_done = 1; m_ch = 0;
                end else begin
                    m_ch++; pulse_at = c + SC + 1;
                end
            end
`ifdef ALIGN_TIMEOUT_EN
            else if (m_wait && c == wait_start + TO) begin
                m_wait = 0; pulse_at = c + SC + 1;
            end
`endif
            if (was_pulse) begin
                m_wait = 1; wait_start = c + 1;
            end
        end
    endtask

    task automatic step(input bit r, input bit t, input bit d);
        rst = r;
        training_start = t;
        data_aligned = d;
        @(posedge clk);
        model(r, t, d);
        cyc++;
        #1;
        if (cyc == pulse_at) m_pulses++;
        if (start_align === 1'b1) dut_pulses++;
        chk("chan_sel", 32'(chan_sel), 32'(m_ch));
        chk("start_align", 32'(start_align), 32'(cyc == pulse_at));
        chk("all_aligned", 32'(all_channels_aligned), 32'(m_done));
    endtask

    task automatic wait_for_wait();
        int n = 0;
        while (!m_wait && n < 2000) begin
            step(0, 0, 0);
            n++;
        end
        chk("wait_bound", 32'(n < 2000), 32'd1);
    endtask

    task automatic advance_to(input int ch);
        step(0, 1, 0);
        for (int k = 0; k < ch; k++) begin
            wait_for_wait();
            step(0, 0, 1);
        end
        wait_for_wait();
    endtask

    task automatic sweep(input int dly);
        int p0, m0;
        p0 = dut_pulses;
        m0 = m_pulses;
        step(0, 1, 0);
        chk("retrain_drop", 32'(all_channels_aligned), 32'd0);
        for (int k = 0; k < NC; k++) begin
            wait_for_wait();
            repeat (dly) step(0, 0, 0);
            step(0, 0, 1);
        end
        chk("sweep_done", 32'(all_channels_aligned), 32'd1);
        chk("sweep_ch0", 32'(chan_sel), 32'd0);
        chk("pulse_count", 32'(dut_pulses - p0), 32'(m_pulses - m0));
        repeat (5) step(0, 0, 0);
    endtask

    initial begin
        // reset 110 ns at 200 MHz
        repeat (22) step(1, 0, 0);
        repeat (30) step(0, 0, 0);
        // spurious data_aligned while idle
        repeat (10) step(0, 0, 1'($urandom_range(0, 1)));

        sweep(200);
        sweep($urandom_range(0, 12));

        // data_aligned during SETTLE is ignored
        step(0, 1, 0);
        step(0, 0, 1);
        step(0, 0, 1);
        wait_for_wait();
        step(0, 0, 1);

        // restart and data_aligned together at channel 5
        advance_to(5);
        chk("at_ch5", 32'(chan_sel), 32'd5);
        step(0, 1, 1);
        chk("prio_ch0", 32'(chan_sel), 32'd0);
        repeat (SC + 3) step(0, 0, 0);

        // reset while waiting on channel 3
        advance_to(3);
        step(1, 0, 0);
        repeat (8) step(0, 0, 0);
        sweep(3);

`ifdef ALIGN_TIMEOUT_EN
        // withhold data_aligned on channel 2
        advance_to(2);
        repeat (3 * (TO + SC + 2) + 4) step(0, 0, 0);
        wait_for_wait();
        step(0, 0, 1);
        chk("retry_adv", 32'(chan_sel), 32'd3);
`endif

        // random traffic
        for (int i = 0; i < 20000; i++) begin
            bit r, t, d;
            r = ($urandom_range(0, 499) == 0);
            t = ($urandom_range(0, 299) == 0) ||
                ((m_done || pulse_at < 0) && $urandom_range(0, 19) == 0);
            d = m_wait ? ($urandom_range(0, 7) == 0)
                       : ($urandom_range(0, 15) == 0);
            step(r, t, d);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/resource_sharing_control.md
Name: resource_sharing_control

Overview:
Sequencer that time-shares one ISERDES/IODELAY alignment engine across several ADC data channels. On a training request it steps `chan_sel` through channels 0..NUM_CHANNELS-1. For each channel it lets the channel mux settle, then pulses `start_align` and waits for the engine's `data_aligned`. When the last channel reports aligned, it raises `all_channels_aligned`. Sits between the ADC-top training control and the shared bit/word-alignment block.

Parameters:
- NUM_CHANNELS, 10, number of channels sequenced; legal 1..16.
- SETTLE_CYCLES, 4, clocks `chan_sel` is held stable before `start_align`; legal 1..255.
- TIMEOUT_CYCLES, 4096, watchdog length per alignment attempt; used only with ALIGN_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- training_start  in  1  one-cycle request to (re)start alignment of all channels.
- data_aligned  in  1  one-cycle pulse from the shared engine: current channel aligned.
- chan_sel  out  4  index of the channel currently routed to the engine.
- start_align  out  1  one-cycle pulse: engine starts aligning channel `chan_sel`.
- all_channels_aligned  out  1  level; high once every channel has aligned.

Behaviour:
- Interface (already decided): one clock `clk`; reset `rst` is synchronous and active-high.
- All outputs are registered. Reset values: chan_sel=0, start_align=0, all_channels_aligned=0, state=IDLE, counters=0.
- States:
  - IDLE: outputs held; waits for training_start.
  - SETTLE: settle counter counts SETTLE_CYCLES clocks, then the FSM goes to PULSE.
  - PULSE: start_align=1 for exactly this one cycle; next state WAIT.
  - WAIT: holds chan_sel; waits for data_aligned.
  - DONE: all_channels_aligned=1; chan_sel=0.
- training_start sampled high at edge N, in any state including mid-sequence or DONE:
  - at N+1: chan_sel=0, all_channels_aligned=0, settle counter cleared, state SETTLE.
  - start_align is high during the cycle after edge N+SETTLE_CYCLES+1, i.e. SETTLE_CYCLES+1 cycles after training_start.
- WAIT with data_aligned high and chan_sel < NUM_CHANNELS-1: chan_sel increments next edge; state SETTLE. The next start_align follows SETTLE_CYCLES+1 cycles after that edge.
- WAIT with data_aligned high and chan_sel == NUM_CHANNELS-1: next edge enters DONE; all_channels_aligned=1 and chan_sel=0. DONE holds until training_start or rst.
- data_aligned outside WAIT (IDLE, SETTLE, PULSE, DONE) is ignored.
- training_start and data_aligned high in the same cycle: training_start wins (restart from channel 0).
- rst has priority over everything and may be asserted mid-sequence; it returns the block to IDLE with reset values.
- start_align never exceeds one cycle and is never high in IDLE, SETTLE, WAIT or DONE.
- chan_sel never exceeds NUM_CHANNELS-1. Its width is fixed at 4; unused high values are never produced.

Optional Feature:
Macro ALIGN_TIMEOUT_EN.
- Defined: WAIT runs a watchdog counter, cleared on entry to WAIT. If TIMEOUT_CYCLES clocks pass without data_aligned, the FSM returns to SETTLE for the same chan_sel and re-issues start_align (retry indefinitely). data_aligned on the exact timeout cycle counts as success.
- Not defined: no watchdog logic; WAIT waits forever.

Test Plan:
- Reset then idle: rst=1 for 110 ns at 200 MHz, release, no stimulus -> chan_sel=0, start_align=0, all_channels_aligned=0 held indefinitely.
- Full sweep: training_start pulse, then a data_aligned pulse ~1 µs after each start_align, 10 times (defaults) -> chan_sel steps 0..9; exactly 10 start_align pulses, each SETTLE_CYCLES+1 cycles after training_start or the preceding data_aligned edge; all_channels_aligned=1 one cycle after the 10th data_aligned, with chan_sel=0.
- Re-training: after DONE, pulse training_start and repeat the sweep -> all_channels_aligned drops to 0 the next cycle and the sweep repeats identically, ending with all_channels_aligned=1.
- Spurious/priority: data_aligned during SETTLE or IDLE -> ignored, chan_sel unchanged. training_start and data_aligned together at chan_sel=5 -> chan_sel=0, sequence restarts.
- Mid-sequence reset: rst while chan_sel=3 in WAIT -> next cycle all outputs at reset values; a later training_start begins again at channel 0.
- ALIGN_TIMEOUT_EN with TIMEOUT_CYCLES=16: withhold data_aligned on channel 2 -> start_align re-pulses every 16+SETTLE_CYCLES+2 cycles with chan_sel=2; supplying data_aligned then advances to channel 3.
